// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Row-scanned 4x4 keypad reader with scan-level debounce and a
//               valid/ready key event output.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    output logic [ROWS-1:0]               row_n,
    input  logic [COLS-1:0]               col_n,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          key_held,
    output logic                          overrun
);

    localparam int              c_CODE_W   = $clog2(ROWS*COLS);
    localparam int              c_ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int              c_COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(ROWS-1);
    localparam logic [ROWS-1:0] c_ROW_ONE  = ROWS'(1);
    localparam logic [3:0]      c_DEB      = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_PRESSED  = 2'd2;

    logic [COLS-1:0]     r_sync1, r_sync2;
    logic [c_ROW_W-1:0]  r_row;
    logic [ROWS-1:0]     r_row_n;
    logic [1:0]          r_scan_cnt;
    logic [c_CODE_W-1:0] r_scan_first;
    logic [1:0]          r_state;
    logic [c_CODE_W-1:0] r_cand;
    logic [3:0]          r_cnt, r_rcnt;
    logic                r_held;
    logic [c_CODE_W-1:0] r_key_code;
    logic                r_key_valid, r_overrun;

    logic [COLS-1:0]     w_row_hit;
    logic [1:0]          w_row_cnt;
    logic [c_COL_W-1:0]  w_row_col;
    logic [c_CODE_W-1:0] w_row_code;
    logic [1:0]          w_scan_cnt;
    logic [c_CODE_W-1:0] w_scan_first;
    logic [c_ROW_W-1:0]  w_row_next;
    logic                w_close, w_single, w_none;
    logic                w_accept;
    logic [c_CODE_W-1:0] w_accept_code;

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_held;
    assign overrun   = r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    // Lowest pressed column and a 0/1/2+ count for the row being sampled.
    always_comb begin
        w_row_hit = ~r_sync2;
        w_row_cnt = 2'd0;
        w_row_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (w_row_hit[c_COL_W'(c)]) begin
                w_row_col = c_COL_W'(c);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_row_hit[c_COL_W'(c)] && (w_row_cnt != 2'd2)) begin
                w_row_cnt = w_row_cnt + 2'd1;
            end
        end
    end

    assign w_row_code = c_CODE_W'(int'(r_row) * COLS + int'(w_row_col));

    always_comb begin
        w_scan_cnt = 2'd2;
        if (r_scan_cnt == 2'd0) begin
            w_scan_cnt = w_row_cnt;
        end else if ((r_scan_cnt == 2'd1) && (w_row_cnt == 2'd0)) begin
            w_scan_cnt = 2'd1;
        end
    end

    assign w_scan_first = (r_scan_cnt == 2'd0) ? w_row_code : r_scan_first;
    assign w_close      = tick && (r_row == c_LAST_ROW);
    assign w_single     = (w_scan_cnt == 2'd1);
    assign w_none       = (w_scan_cnt == 2'd0);
    assign w_row_next   = (r_row == c_LAST_ROW) ? '0 : r_row + c_ROW_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row        <= '0;
            r_row_n      <= ~c_ROW_ONE;
            r_scan_cnt   <= 2'd0;
            r_scan_first <= '0;
        end else if (tick) begin
            if (w_close) begin
                r_scan_cnt   <= 2'd0;
                r_scan_first <= '0;
            end else begin
                r_scan_cnt   <= w_scan_cnt;
                r_scan_first <= w_scan_first;
            end
            r_row   <= w_row_next;
            r_row_n <= ~(c_ROW_ONE << w_row_next);
        end
    end

    always_comb begin
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        if (w_close) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_single && (c_DEB == 4'd1)) begin
                        w_accept      = 1'b1;
                        w_accept_code = w_scan_first;
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_single && (w_scan_first == r_cand) && (r_cnt + 4'd1 == c_DEB)) begin
                        w_accept = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= 4'd0;
            r_rcnt  <= 4'd0;
            r_held  <= 1'b0;
        end else if (w_close) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_single) begin
                        r_cand <= w_scan_first;
                        if (c_DEB == 4'd1) begin
                            r_state <= c_ST_PRESSED;
                            r_held  <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_rcnt  <= 4'd0;
                        end else begin
                            r_state <= c_ST_DEBOUNCE;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_single && (w_scan_first == r_cand)) begin
                        if (r_cnt + 4'd1 == c_DEB) begin
                            r_state <= c_ST_PRESSED;
                            r_held  <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_rcnt  <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                c_ST_PRESSED: begin
                    // Any key activity restarts the release count: no rollover.
                    if (w_none) begin
                        if (r_rcnt + 4'd1 == c_DEB) begin
                            r_state <= c_ST_IDLE;
                            r_held  <= 1'b0;
                            r_rcnt  <= 4'd0;
                        end else begin
                            r_rcnt <= r_rcnt + 4'd1;
                        end
                    end else begin
                        r_rcnt <= 4'd0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // A transfer in the same cycle frees the slot for the new event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept && (!r_key_valid || key_ready)) begin
                r_key_code  <= w_accept_code;
                r_key_valid <= 1'b1;
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
            if (w_accept && r_key_valid && !key_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner against a scan-level
//               reference model of the keypad and debounce rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DS   = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        tick      = 1'b0;
    logic        key_ready = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid, key_held, overrun;
    logic [15:0] pressed = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_ticks  = 0;
    int phase    = 0;

    int m_row, m_n, m_first, run_key, run_len, quiet, m_code;
    bit m_held, m_valid, m_over;

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Membrane keypad: a pressed key shorts its row line to its column line.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[2'(r)] && pressed[4'(r*4+c)]) col_n[2'(c)] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_n = 0; m_first = 0; run_key = 0; run_len = 0; quiet = 0;
        m_code = 0; m_held = 0; m_valid = 0; m_over = 0;
    endtask

    task automatic model_update();
        bit xfer, acc;
        int acc_code;
        if (!rst) begin
            model_reset();
            return;
        end
        xfer = m_valid && key_ready;
        acc = 0;
        acc_code = 0;
        if (tick) begin
            for (int c = 0; c < COLS; c++) begin
                if (pressed[4'(m_row*COLS+c)]) begin
                    if (m_n == 0) m_first = m_row*COLS + c;
                    if (m_n < 2) m_n++;
                end
            end
            if (m_row == ROWS-1) begin
                if (!m_held) begin
                    if (m_n == 1 && run_len > 0 && run_key == m_first) run_len++;
                    else if (m_n == 1 && run_len == 0) begin
                        run_key = m_first;
                        run_len = 1;
                    end else run_len = 0;
                    if (run_len == DS) begin
                        acc = 1; acc_code = run_key; m_held = 1; run_len = 0; quiet = 0;
                    end
                end else begin
                    if (m_n == 0) begin
                        quiet++;
                        if (quiet == DS) begin m_held = 0; quiet = 0; end
                    end else quiet = 0;
                end
                m_n = 0;
                m_first = 0;
            end
            m_row = (m_row + 1) % ROWS;
        end
        if (acc) begin
            if (!m_valid || xfer) begin m_valid = 1; m_code = acc_code; end
            else m_over = 1;
        end else if (xfer) m_valid = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] e_row;
        e_row = ~(4'b0001 << m_row);
        check("row_n", 32'(row_n), 32'(e_row));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_code", 32'(key_code), m_code);
        check("key_held", 32'(key_held), 32'(m_held));
        check("overrun", 32'(overrun), 32'(m_over));
    endtask

    task automatic step();
        tick = (phase == 3);
        if (key_valid && key_ready) n_xfer++;
        @(posedge clk);
        model_update();
        if (tick) n_ticks++;
        phase = rst ? (phase + 1) % 4 : 0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_ticks(input int n);
        int target, guard;
        target = n_ticks + n;
        guard = 0;
        while (n_ticks < target && guard < n*8 + 8) begin
            step();
            guard++;
        end
    endtask

    task automatic run_scans(input int n);
        run_ticks(n*ROWS);
    endtask

    task automatic align();
        run_ticks(1);
        while (m_row != 0) run_ticks(1);
    endtask

    initial begin
        logic [3:0] row_tab [4];
        int x0, t0, g, k;
        row_tab = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        model_reset();

        // Reset state
        @(negedge clk);
        repeat (3) step();
        check("rst_row_n", 32'(row_n), 32'h0000000e);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;

        // Row drive sequence
        for (int i = 0; i < 4; i++) begin
            run_ticks(1);
            check("row_seq", 32'(row_n), 32'(row_tab[i]));
        end

        // Hold key 9 (row 2, col 1)
        x0 = n_xfer;
        t0 = n_ticks;
        pressed = 16'(1 << 9);
        g = 0;
        while (!key_valid && g < 200) begin step(); g++; end
        check("latency_ticks", n_ticks - t0, 16);
        check("hold_code", 32'(key_code), 9);
        run_scans(96);
        check("hold_events", n_xfer - x0, 1);
        check("hold_held", 32'(key_held), 1);
        align();
        pressed = '0;
        run_scans(3);
        check("release_held3", 32'(key_held), 1);
        run_scans(1);
        check("release_held4", 32'(key_held), 0);
        check("release_events", n_xfer - x0, 1);

        // Bounce on key 5
        align();
        x0 = n_xfer;
        pressed = 16'(1 << 5);
        for (int i = 0; i < 8; i++) begin
            run_ticks(5);
            pressed = pressed ^ 16'(1 << 5);
        end
        check("bounce_quiet", n_xfer - x0, 0);
        run_scans(4);
        check("bounce_valid", 32'(key_valid), 1);
        check("bounce_code", 32'(key_code), 5);
        pressed = '0;
        run_scans(5);
        check("bounce_events", n_xfer - x0, 1);

        // Simultaneous keys 3 and 12
        align();
        x0 = n_xfer;
        pressed = 16'((1 << 3) | (1 << 12));
        run_scans(6);
        check("multi_events", n_xfer - x0, 0);
        check("multi_held", 32'(key_held), 0);
        pressed = 16'(1 << 3);
        run_scans(4);
        check("multi_valid", 32'(key_valid), 1);
        check("multi_code", 32'(key_code), 3);
        pressed = '0;
        run_scans(5);

        // Overrun with consumer stalled
        key_ready = 1'b0;
        align();
        pressed = 16'(1 << 7);
        run_scans(5);
        pressed = '0;
        run_scans(5);
        pressed = 16'(1 << 0);
        run_scans(5);
        check("ovr_valid", 32'(key_valid), 1);
        check("ovr_code", 32'(key_code), 7);
        check("ovr_flag", 32'(overrun), 1);
        key_ready = 1'b1;
        step();
        check("ovr_drain_valid", 32'(key_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        align();
        pressed = '0;
        run_scans(5);

        // Async reset mid-debounce
        align();
        x0 = n_xfer;
        pressed = 16'(1 << 10);
        run_scans(2);
        #2 rst = 1'b0;
        #1;
        check("arst_row_n", 32'(row_n), 32'h0000000e);
        check("arst_valid", 32'(key_valid), 0);
        check("arst_held", 32'(key_held), 0);
        check("arst_overrun", 32'(overrun), 0);
        model_reset();
        phase = 0;
        pressed = '0;
        @(negedge clk);
        repeat (2) step();
        rst = 1'b1;
        run_scans(6);
        check("arst_no_event", n_xfer - x0, 0);

        // Acceptance of key 8 coincides with transfer of key 4
        key_ready = 1'b0;
        align();
        pressed = 16'(1 << 4);
        run_scans(5);
        check("coin_first_code", 32'(key_code), 4);
        pressed = '0;
        run_scans(5);
        pressed = 16'(1 << 8);
        run_ticks(15);
        while (phase != 3) step();
        key_ready = 1'b1;
        step();
        check("coin_valid", 32'(key_valid), 1);
        check("coin_code", 32'(key_code), 8);
        check("coin_overrun", 32'(overrun), 0);
        step();
        check("coin_drain", 32'(key_valid), 0);
        align();
        pressed = '0;
        run_scans(5);

        // Randomized presses, key switches and consumer stalls
        for (int it = 0; it < 30; it++) begin
            key_ready = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 15);
            pressed = 16'(1 << k);
            if ($urandom_range(0, 3) == 0) pressed = pressed | 16'(1 << $urandom_range(0, 15));
            run_ticks($urandom_range(4, 28));
            if ($urandom_range(0, 3) == 0) begin
                pressed = 16'(1 << $urandom_range(0, 15));
                run_ticks($urandom_range(4, 24));
            end
            key_ready = 1'($urandom_range(0, 1));
            pressed = '0;
            run_ticks($urandom_range(4, 24));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the time-multiplexed 7-segment display path.
- The display drives digit-select lines one at a time from the shared scan tick and writes segments. This block drives keypad row lines one at a time from the same tick and reads the column lines back.
- It debounces presses and delivers one key code per press over a valid/ready handshake, for the display or priority logic to consume.
- Targets a 4x4 membrane keypad on the board PMOD. Column lines have pull-ups.

Parameters:
- ROWS, 4: number of row drive lines.
- COLS, 4: number of column sense lines.
- DEBOUNCE_SCANS, 4: number of consecutive identical full scans required to accept a press or a release. Legal range 1..15.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset, asynchronous, active-low.
- tick  input  1  scan-step enable, one clk wide, from the clock-enable divider.
- row_n  output  ROWS  row drive, one-cold, active-low.
- col_n  input  COLS  column sense, active-low, asynchronous to clk.
- key_code  output  $clog2(ROWS*COLS)  accepted key = row*COLS + col.
- key_valid  output  1  key_code holds an unconsumed event.
- key_ready  input  1  consumer accepts the event.
- key_held  output  1  an accepted key is still physically pressed.
- overrun  output  1  sticky: a press was accepted while key_valid was still high.

Behaviour:
- Reset values:
  - row_n = ~1 (row 0 driven).
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0.
  - Row index = 0, FSM = IDLE, all counters = 0.
  - Both sync flops = all ones.
- col_n passes through a 2-flop synchronizer. The bench must keep the tick period at 3 clk or more so the sampled value reflects the current row.
- Scan step, on each clk edge with tick = 1:
  - Sample the synchronized columns for the current row r.
  - Advance r (wrap ROWS-1 -> 0) and update row_n = ~(1 << r_next).
  - Without tick, nothing changes except the handshake logic.
- Per-scan accumulation:
  - Track the first pressed key in row-major order (lowest row, then lowest column).
  - Track a saturating count of pressed keys (0, 1, 2+).
- At the sample of row ROWS-1 the scan closes with result NONE, SINGLE(code) or MULTI. Accumulators clear for the next scan in the same cycle.
- Debounce FSM, evaluated at scan close only:
  - IDLE:
    - SINGLE(c) -> cand = c, cnt = 1. If DEBOUNCE_SCANS = 1, accept immediately; otherwise go to DEBOUNCE.
    - NONE or MULTI -> stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS -> accept, go to PRESSED.
    - Any other result -> IDLE, cnt = 0.
  - PRESSED:
    - key_held = 1.
    - NONE -> rcnt++. When rcnt reaches DEBOUNCE_SCANS -> IDLE, key_held = 0.
    - SINGLE or MULTI (any key) -> rcnt = 0, stay in PRESSED.
    - No second event is generated until a full release (no rollover).
- Accept, in the same clk as scan close:
  - If key_valid = 0: key_code = cand, key_valid = 1 from the next cycle.
  - If key_valid = 1: key_code is unchanged, the new event is dropped, and overrun = 1 (cleared only by reset).
- Handshake:
  - Transfer happens on any clk edge with key_valid & key_ready. key_valid = 0 the next cycle; key_code keeps its value.
  - key_ready while key_valid = 0 has no effect.
  - Accept and transfer in the same cycle: the transfer completes and the new event loads (valid stays 1, code updates, no overrun).
- Latency: a stable press starting at a scan boundary gives key_valid after DEBOUNCE_SCANS*ROWS ticks + 1 clk (+2 clk of sync).
- Async reset mid-scan or mid-debounce returns everything to reset values immediately. A pending event is lost.
- The first scan after reset starts at row 0 and is a complete scan.

Test Plan:
- ROWS = COLS = 4, DEBOUNCE_SCANS = 4, tick every 4 clk, key_ready = 1. Press row 2, col 1 and hold 100 scans -> key_code = 9, one key_valid pulse exactly 16 ticks after the first full scan boundary, key_held = 1. Release -> key_held = 0 after 4 empty scans, no second pulse.
- Bounce: key 5 toggles every 5 ticks for 10 scans, then is stable -> no event during bouncing, exactly one event with code 5 after 4 stable scans.
- Simultaneous keys 3 and 12 pressed together -> MULTI every scan, no event, key_held = 0. Release 12 while holding 3 -> event with code 3 after 4 scans.
- key_ready = 0: press and release key 7, then press key 0 -> key_valid = 1, key_code = 7, overrun = 1. Raise key_ready -> key_valid = 0 next clk, overrun stays 1.
- Accept and transfer coincide: hold key_ready so the transfer of key 4 lands in the same clk as the acceptance of key 8 -> key_valid stays 1, key_code = 8, overrun = 0.
- Row drive sequence: row_n cycles 1110, 1101, 1011, 0111 and wraps, advancing on each tick. Assert rst (low) mid-debounce -> row_n = 1110, key_valid = 0 and FSM = IDLE immediately, with no event from the interrupted press.
